// File: rtl/chopper_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : chopper_sequencer
// Description : Two-channel peak-current chopper sequencer. Each bridge
//               (channel 0 = A, channel 1 = B) runs an independent
//               BLANK -> SENSE -> OFF cycle. The blank and off countdowns
//               are consumed by the bridge-drive logic. A sticky
//               minimum-on-time fault is shared by both channels.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                     system clock
//   resetn                  synchronous active-low reset
//   enable                  driver enable; low parks both channels in IDLE
//   config_blanktime[7:0]   blank period in cycles, sampled at load
//   config_offtime[9:0]     off period in cycles, sampled at load
//   config_minimum_on_time  minimum BLANK-start-to-off-request distance
//   offtimer_en[1:0]        per-channel off request (comparator tripped)
//   phase_step[1:0]         per-channel microstep phase-change pulse
//   blank_timer0/1[7:0]     blank countdown, 0 = not blanking
//   off_timer0/1[9:0]       off countdown, 0 = not in off time
//   off_active[1:0]         channel currently in OFF
//   faultn                  sticky minimum-on fault, active low
//   chop_count0/1[15:0]     wrapping count of OFF entries per channel
// ============================================================================
module chopper_sequencer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic [7:0]  config_blanktime,
    input  logic [9:0]  config_offtime,
    input  logic [7:0]  config_minimum_on_time,
    input  logic [1:0]  offtimer_en,
    input  logic [1:0]  phase_step,
    output logic [7:0]  blank_timer0,
    output logic [7:0]  blank_timer1,
    output logic [9:0]  off_timer0,
    output logic [9:0]  off_timer1,
    output logic [1:0]  off_active,
    output logic        faultn,
    output logic [15:0] chop_count0,
    output logic [15:0] chop_count1
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SENSE = 2'd2,
        ST_OFF   = 2'd3
    } state_t;

    localparam int NUM_CH = 2;

    // Per-channel state, indexed by channel number.
    state_t      state_q [NUM_CH];
    state_t      state_d [NUM_CH];
    logic [7:0]  blank_q [NUM_CH];
    logic [7:0]  blank_d [NUM_CH];
    logic [9:0]  off_q   [NUM_CH];
    logic [9:0]  off_d   [NUM_CH];
    logic [7:0]  oncnt_q [NUM_CH];
    logic [7:0]  oncnt_d [NUM_CH];
    logic [15:0] chop_q  [NUM_CH];
    logic [15:0] chop_d  [NUM_CH];

    logic        faultn_q;
    logic        faultn_d;
    logic [1:0]  fault_set;

    // ------------------------------------------------------------------------
    // Next-state logic for both channels.
    // ------------------------------------------------------------------------
    always_comb begin
        fault_set = 2'b00;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            blank_d[i] = blank_q[i];
            off_d[i]   = off_q[i];
            oncnt_d[i] = oncnt_q[i];
            chop_d[i]  = chop_q[i];

            if (!enable) begin
                // Disable parks the channel but keeps chop_count history.
                state_d[i] = ST_IDLE;
                blank_d[i] = 8'd0;
                off_d[i]   = 10'd0;
                oncnt_d[i] = 8'd0;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        state_d[i] = ST_BLANK;
                        blank_d[i] = config_blanktime;
                        oncnt_d[i] = 8'd0;
                    end

                    ST_BLANK: begin
                        oncnt_d[i] = (oncnt_q[i] == 8'hFF) ? 8'hFF : oncnt_q[i] + 8'd1;
                        // A loaded 0 leaves after one cycle, same as a 1.
                        if (blank_q[i] <= 8'd1) begin
                            state_d[i] = ST_SENSE;
                            blank_d[i] = 8'd0;
                        end else begin
                            blank_d[i] = blank_q[i] - 8'd1;
                        end
                    end

                    ST_SENSE: begin
                        oncnt_d[i] = (oncnt_q[i] == 8'hFF) ? 8'hFF : oncnt_q[i] + 8'd1;
                        // The off request has priority over a phase step.
                        if (offtimer_en[i]) begin
                            state_d[i] = ST_OFF;
                            off_d[i]   = config_offtime;
                            chop_d[i]  = chop_q[i] + 16'd1;
                            // on_count is compared before this cycle's increment.
                            if (oncnt_q[i] < config_minimum_on_time) begin
                                fault_set[i] = 1'b1;
                            end
                        end else if (phase_step[i]) begin
                            state_d[i] = ST_BLANK;
                            blank_d[i] = config_blanktime;
                            oncnt_d[i] = 8'd0;
                        end
                    end

                    ST_OFF: begin
                        // offtime 0 still produces a single OFF cycle.
                        if (off_q[i] <= 10'd1) begin
                            state_d[i] = ST_BLANK;
                            off_d[i]   = 10'd0;
                            blank_d[i] = config_blanktime;
                            oncnt_d[i] = 8'd0;
                        end else begin
                            off_d[i] = off_q[i] - 10'd1;
                        end
                    end

                    default: begin
                        state_d[i] = ST_IDLE;
                        blank_d[i] = 8'd0;
                        off_d[i]   = 10'd0;
                        oncnt_d[i] = 8'd0;
                    end
                endcase
            end
        end

        // Sticky: once low, only reset brings faultn back high.
        faultn_d = faultn_q & ~(|fault_set);
    end

    // ------------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_IDLE;
                blank_q[i] <= 8'd0;
                off_q[i]   <= 10'd0;
                oncnt_q[i] <= 8'd0;
                chop_q[i]  <= 16'd0;
            end
            faultn_q <= 1'b1;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                blank_q[i] <= blank_d[i];
                off_q[i]   <= off_d[i];
                oncnt_q[i] <= oncnt_d[i];
                chop_q[i]  <= chop_d[i];
            end
            faultn_q <= faultn_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs, all taken straight from registers.
    // ------------------------------------------------------------------------
    assign blank_timer0 = blank_q[0];
    assign blank_timer1 = blank_q[1];
    assign off_timer0   = off_q[0];
    assign off_timer1   = off_q[1];
    assign chop_count0  = chop_q[0];
    assign chop_count1  = chop_q[1];
    assign off_active   = {state_q[1] == ST_OFF, state_q[0] == ST_OFF};
    assign faultn       = faultn_q;

endmodule
`default_nettype wire
